regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRSIZE, default 5, register address width; WORDSIZE, default 32, data width; DEPTH, default 2, per-requester queue depth (power of 2, >=2).
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0Valid/req0Ready  in/out  1/1  ALU writeback handshake; req0Addr  in  ADDRSIZE; req0Data  in  WORDSIZE.
REQ-005 req1Valid/req1Ready  in/out  1/1  load writeback handshake; req1Addr  in  ADDRSIZE; req1Data  in  WORDSIZE.
REQ-006 regWrite  out  1; writeReg  out  ADDRSIZE; writeData  out  WORDSIZE -- the single register file write port.
REQ-007 query1Addr, query2Addr  in  ADDRSIZE; query1Pending, query2Pending  out  1 -- pending-write lookup for the two read ports.

Function
REQ-008 Each requester SHALL own a DEPTH-entry FIFO; a transfer occurs on a posedge where reqNValid && reqNReady.
REQ-009 reqNReady SHALL equal !fullN, with no bypass; a full FIFO SHALL NOT accept, even when it pops in the same cycle.
REQ-010 A transfer with reqNAddr == 0 SHALL be accepted and discarded: no enqueue, no write, never pending.
REQ-011 Per cycle at most one head SHALL be popped: only one queue non-empty -> pop it; both non-empty -> pop the requester not granted last (round-robin, lastGrant register).
REQ-012 A popped entry SHALL be registered onto writeReg/writeData with regWrite=1 in the cycle after the pop edge; regWrite SHALL be 0 in any cycle following an edge with no pop.
REQ-013 Latency: transfer at edge k -> earliest pop at edge k+1 -> regWrite high during cycle k+1..k+2 -> register file write at edge k+2.
REQ-014 Writes from one requester SHALL reach the write port in acceptance order; ordering between requesters is defined only by REQ-011.
REQ-015 A FIFO SHALL support simultaneous push and pop when not full; occupancy then stays unchanged; read/write pointers wrap modulo DEPTH.
REQ-016 queryNPending SHALL be combinational: 1 iff queryNAddr != 0 and it matches any valid entry of either FIFO or (regWrite && writeReg == queryNAddr).
REQ-017 writeReg/writeData SHALL hold their last values when regWrite=0.

Reset
REQ-018 reset SHALL asynchronously empty both FIFOs (pointers and counts to 0), clear regWrite, writeReg and writeData to 0, and set lastGrant=1 so requester 0 wins the first contention.
REQ-019 During reset, reqNReady SHALL be 0 and both queryNPending outputs SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL discard all queued and in-flight writes; no regWrite pulse SHALL follow deassertion until a new transfer.

Structure
REQ-021 Package regfile_pkg SHALL hold ADDRSIZE/WORDSIZE defaults, the DEPTH default and the requester-ID constants (REQ_ALU=0, REQ_LOAD=1).
REQ-022 Sub-module wb_fifo (push/pop, full/empty, per-entry valid and address taps for lookup) SHALL be instantiated twice; arbitration, output register and lookup logic SHALL stay in regfile_wr_arbiter.

Verification
REQ-023 Single write: req0 addr 5, data 0xDEADBEEF at edge 1 -> regWrite=1, writeReg=5, writeData=0xDEADBEEF in the cycle after edge 2; query1Addr=5 pending from after edge 1 until after edge 3.
REQ-024 Contention: both queues hold 2 entries (r0: x1,x2; r1: x3,x4) -> write order x1,x3,x2,x4 on consecutive cycles.
REQ-025 Full: hold req1 valid with no contention lost, pop blocked by r0 priority -> after 2 accepts req1Ready=0; third entry is accepted only after a pop.
REQ-026 x0 filter: req0 addr 0, data 0x1234 -> accepted (ready=1), no regWrite pulse, query addr 0 never pending.
REQ-027 Reset mid-flight: 3 entries queued, reset for 1 cycle -> regWrite=0 immediately, all pending=0, no writes after release.
REQ-028 Streaming: req0 valid every cycle addr 1..8 -> ready stays 1, regWrite high for 8 consecutive cycles in order 1..8.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared defaults and requester identifiers for the register file
//             write-port arbiter and its writeback FIFOs.
//  Contents : DEF_ADDRSIZE / DEF_WORDSIZE / DEF_DEPTH defaults,
//             REQ_ALU / REQ_LOAD requester IDs.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_ADDRSIZE = 5;
    localparam int DEF_WORDSIZE = 32;
    localparam int DEF_DEPTH    = 2;

    // Requester IDs, also the encoding of the lastGrant register
    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : DEPTH-entry writeback queue (address + data) with per-entry
//             valid and address taps so the owner can answer pending-write
//             lookups without draining the queue.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             push_i/push_addr_i/push_data_i - enqueue (caller ensures !full)
//             pop_i              - dequeue head (caller ensures !empty)
//             full_o, empty_o    - occupancy flags
//             head_addr_o/head_data_o - current head entry
//             entry_valid_o/entry_addr_o - lookup taps, one per slot
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push_i,
    input  logic [ADDRSIZE-1:0]                push_addr_i,
    input  logic [WORDSIZE-1:0]                push_data_i,
    input  logic                               pop_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [ADDRSIZE-1:0]                head_addr_o,
    output logic [WORDSIZE-1:0]                head_data_o,
    output logic [DEPTH-1:0]                   entry_valid_o,
    output logic [DEPTH-1:0][ADDRSIZE-1:0]     entry_addr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDRSIZE-1:0] addr_q [DEPTH];
    logic [WORDSIZE-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q, count_d;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_addr_o = addr_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign entry_valid_o = valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign entry_addr_o[g] = addr_q[g];
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are PW bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            // Push and pop never target the same slot: a pop needs a
            // non-empty queue and a push needs a non-full one.
            if (push_i) begin
                addr_q[wptr_q]  <= push_addr_i;
                data_q[wptr_q]  <= push_data_i;
                valid_q[wptr_q] <= 1'b1;
                wptr_q          <= wptr_q + PW'(1);
            end
            if (pop_i) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + PW'(1);
            end
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Merges ALU (req0) and load (req1) writebacks onto the single
//             register file write port. Each requester has its own queue;
//             one head is popped per cycle with round-robin on contention,
//             and the popped entry is registered onto the write port.
//  Ports    : clk, reset                   - clock, async active-high reset
//             req0Valid/Ready/Addr/Data    - ALU writeback handshake
//             req1Valid/Ready/Addr/Data    - load writeback handshake
//             regWrite/writeReg/writeData  - register file write port
//             query{1,2}Addr/Pending       - pending-write lookup for reads
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0Valid,
    output logic                req0Ready,
    input  logic [ADDRSIZE-1:0] req0Addr,
    input  logic [WORDSIZE-1:0] req0Data,
    input  logic                req1Valid,
    output logic                req1Ready,
    input  logic [ADDRSIZE-1:0] req1Addr,
    input  logic [WORDSIZE-1:0] req1Data,
    output logic                regWrite,
    output logic [ADDRSIZE-1:0] writeReg,
    output logic [WORDSIZE-1:0] writeData,
    input  logic [ADDRSIZE-1:0] query1Addr,
    input  logic [ADDRSIZE-1:0] query2Addr,
    output logic                query1Pending,
    output logic                query2Pending
);

    logic                           full0, empty0, full1, empty1;
    logic                           push0, push1, pop0, pop1;
    logic [ADDRSIZE-1:0]            head0_addr, head1_addr;
    logic [WORDSIZE-1:0]            head0_data, head1_data;
    logic [DEPTH-1:0]               ev0, ev1;
    logic [DEPTH-1:0][ADDRSIZE-1:0] ea0, ea1;

    logic                lastGrant_q, lastGrant_d;
    logic                regWrite_q;
    logic [ADDRSIZE-1:0] writeReg_q;
    logic [WORDSIZE-1:0] writeData_q;

    // Ready is purely the queue state: no bypass, so a full queue refuses
    // even when its head pops on the same edge.
    assign req0Ready = !full0 && !reset;
    assign req1Ready = !full1 && !reset;

    // Writes to x0 complete the handshake but are dropped here.
    assign push0 = req0Valid && req0Ready && (req0Addr != '0);
    assign push1 = req1Valid && req1Ready && (req1Addr != '0);

    wb_fifo #(.ADDRSIZE(ADDRSIZE), .WORDSIZE(WORDSIZE), .DEPTH(DEPTH)) u_fifo0 (
        .clk           (clk),
        .rst           (reset),
        .push_i        (push0),
        .push_addr_i   (req0Addr),
        .push_data_i   (req0Data),
        .pop_i         (pop0),
        .full_o        (full0),
        .empty_o       (empty0),
        .head_addr_o   (head0_addr),
        .head_data_o   (head0_data),
        .entry_valid_o (ev0),
        .entry_addr_o  (ea0)
    );

    wb_fifo #(.ADDRSIZE(ADDRSIZE), .WORDSIZE(WORDSIZE), .DEPTH(DEPTH)) u_fifo1 (
        .clk           (clk),
        .rst           (reset),
        .push_i        (push1),
        .push_addr_i   (req1Addr),
        .push_data_i   (req1Data),
        .pop_i         (pop1),
        .full_o        (full1),
        .empty_o       (empty1),
        .head_addr_o   (head1_addr),
        .head_data_o   (head1_data),
        .entry_valid_o (ev1),
        .entry_addr_o  (ea1)
    );

    // Arbitration: a lone non-empty queue always wins; on contention the
    // requester that did not win the previous pop is served.
    always_comb begin
        pop0        = 1'b0;
        pop1        = 1'b0;
        lastGrant_d = lastGrant_q;
        if (!empty0 && !empty1) begin
            if (lastGrant_q == REQ_ALU) begin
                pop1        = 1'b1;
                lastGrant_d = REQ_LOAD;
            end else begin
                pop0        = 1'b1;
                lastGrant_d = REQ_ALU;
            end
        end else if (!empty0) begin
            pop0        = 1'b1;
            lastGrant_d = REQ_ALU;
        end else if (!empty1) begin
            pop1        = 1'b1;
            lastGrant_d = REQ_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant_q <= REQ_LOAD;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            regWrite_q  <= pop0 || pop1;
            if (pop0) begin
                writeReg_q  <= head0_addr;
                writeData_q <= head0_data;
            end else if (pop1) begin
                writeReg_q  <= head1_addr;
                writeData_q <= head1_data;
            end
        end
    end

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;

    // A register is pending while it sits in either queue or is being
    // written this cycle; x0 is never pending.
    function automatic logic lookup(input logic [ADDRSIZE-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ev0[i] && (ea0[i] == a)) hit = 1'b1;
            if (ev1[i] && (ea1[i] == a)) hit = 1'b1;
        end
        if (regWrite_q && (writeReg_q == a)) hit = 1'b1;
        return hit && (a != '0);
    endfunction

    assign query1Pending = !reset && lookup(query1Addr);
    assign query2Pending = !reset && lookup(query2Addr);

endmodule : regfile_wr_arbiter
`default_nettype wire
